// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : In-order instruction fetch with PC-tagged buffer and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int              PC_W       = 8,
    parameter int              INS_W      = 32,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    output logic [PC_W-1:0]  imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [INS_W-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             inst_valid,
    output logic [INS_W-1:0] inst_data,
    output logic [PC_W-1:0]  inst_pc,
    input  logic             inst_ready
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W:0]   c_DEPTH_EXT = (c_CNT_W + 1)'(FIFO_DEPTH);

    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [c_CNT_W-1:0] fifo_count_q, fifo_count_d;
    logic [c_CNT_W-1:0] inflight_q, inflight_d;
    logic [c_CNT_W-1:0] drop_q, drop_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [PC_W-1:0]    fifo_pc_q   [FIFO_DEPTH];
    logic [PC_W-1:0]    fifo_pc_d   [FIFO_DEPTH];
    logic [INS_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [INS_W-1:0]   fifo_data_d [FIFO_DEPTH];
    logic [PC_W-1:0]    tag_pc_q    [FIFO_DEPTH];
    logic [PC_W-1:0]    tag_pc_d    [FIFO_DEPTH];

    logic             w_pop, w_rsp, w_push, w_accept, w_credit_ok, w_tag_room;
    logic [c_CNT_W:0] w_occupancy;

    assign inst_valid = (fifo_count_q != '0);
    assign inst_data  = inst_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;

    assign w_pop  = inst_valid & inst_ready;
    assign w_rsp  = imem_rsp_valid & (inflight_q != '0);
    assign w_push = w_rsp & (drop_q == '0) & ~redirect_valid;

    assign w_occupancy = {1'b0, fifo_count_q} + {1'b0, inflight_q} - {1'b0, drop_q}
                         - (c_CNT_W + 1)'(w_pop);
    assign w_credit_ok = (w_occupancy < c_DEPTH_EXT);
    // Responses still owed for flushed requests hold tag slots, so outstanding
    // requests stay bounded by the tag queue depth.
    assign w_tag_room  = (inflight_q != c_DEPTH_CNT) | w_rsp;

    assign imem_req_valid = ~reset & ~redirect_valid & w_credit_ok & w_tag_room;
    assign imem_req_addr  = fetch_pc_q;
    assign w_accept       = imem_req_valid & imem_req_ready;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        fifo_count_d = fifo_count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        inflight_d   = inflight_q + c_CNT_W'(w_accept) - c_CNT_W'(w_rsp);
        drop_d       = drop_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        tag_rd_d     = tag_rd_q;
        tag_wr_d     = tag_wr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_data_d  = fifo_data_q;
        tag_pc_d     = tag_pc_q;

        if (w_accept) begin
            tag_pc_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d           = tag_wr_q + c_PTR_W'(1);
            fetch_pc_d         = fetch_pc_q + PC_W'(4);
        end
        if (w_rsp) begin
            tag_rd_d = tag_rd_q + c_PTR_W'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - c_CNT_W'(1);
            end
        end
        if (w_push) begin
            fifo_pc_d[wr_ptr_q]   = tag_pc_q[tag_rd_q];
            fifo_data_d[wr_ptr_q] = imem_rsp_data;
            wr_ptr_d              = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        if (redirect_valid) begin
            fetch_pc_d   = {redirect_pc[PC_W-1:2], 2'b00};
            drop_d       = inflight_q - c_CNT_W'(w_rsp);
            fifo_count_d = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            fifo_count_q <= '0;
            inflight_q   <= '0;
            drop_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            tag_rd_q     <= '0;
            tag_wr_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            fifo_count_q <= fifo_count_d;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            tag_rd_q     <= tag_rd_d;
            tag_wr_q     <= tag_wr_d;
        end
    end

    // Storage arrays need no reset: every entry is written before it is read.
    always_ff @(posedge clk) begin
        fifo_pc_q   <= fifo_pc_d;
        fifo_data_q <= fifo_data_d;
        tag_pc_q    <= tag_pc_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Brief    : Scoreboard + vector-table bench for inst_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    logic        clk, reset;
    logic        req_valid, req_ready, rsp_valid, redirect_valid, inst_valid, inst_ready;
    logic [7:0]  req_addr, redirect_pc, inst_pc;
    logic [31:0] rsp_data, inst_data;

    logic        req_valid2, rsp_valid2, inst_valid2;
    logic [7:0]  req_addr2, inst_pc2;
    logic [31:0] rsp_data2, inst_data2;

    inst_fetch_unit #(.PC_W(8), .INS_W(32), .FIFO_DEPTH(2), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    inst_fetch_unit #(.PC_W(8), .INS_W(32), .FIFO_DEPTH(2), .RESET_PC(8'hF8)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid2), .imem_req_addr(req_addr2), .imem_req_ready(1'b1),
        .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
        .redirect_valid(1'b0), .redirect_pc(8'h00),
        .inst_valid(inst_valid2), .inst_data(inst_data2), .inst_pc(inst_pc2),
        .inst_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] data; } mem_t;
    typedef struct { logic [7:0] pc; logic [31:0] data; } exp_t;
    typedef struct {
        logic       inst_ready;
        logic       exp_req_valid;
        logic [7:0] exp_addr;
        logic       exp_iv;
        logic [7:0] exp_pc;
    } vec_t;

    mem_t       mem_q[$];
    exp_t       exp_q[$];
    logic [7:0] acc_log[$];
    logic [7:0] pop_log[$];
    int         checks = 0, errors = 0;
    int         cyc = 0, lat = 1;
    logic [7:0] exp_addr = 8'h00;
    logic [7:0] gen = 8'h00;
    logic       prev_acc2 = 1'b0;
    logic [7:0] prev_addr2 = 8'h00;
    vec_t       vecs[9];
    logic [7:0] wrap_addr[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive memory responses for this cycle, then let combinational outputs settle.
    task automatic cyc_begin();
        if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_q[0].data;
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end
        rsp_valid2 = prev_acc2 & ~reset;
        rsp_data2  = {8'hC1, 16'h0, prev_addr2};
        #1;
    endtask

    // Record handshakes that complete at the coming edge, then advance.
    task automatic cyc_end();
        exp_t e;
        if (reset) begin
            mem_q.delete(); exp_q.delete(); acc_log.delete(); pop_log.delete();
            exp_addr  = 8'h00;
            prev_acc2 = 1'b0;
        end else begin
            if (rsp_valid) void'(mem_q.pop_front());
            if (inst_valid && inst_ready) begin
                pop_log.push_back(inst_pc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {24'h0, inst_pc}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", {24'h0, inst_pc}, {24'h0, e.pc});
                    chk("pop_data", inst_data, e.data);
                end
            end
            if (redirect_valid) begin
                chk("no_req_on_redirect", {31'h0, req_valid}, 32'h0);
                exp_q.delete();
                exp_addr = {redirect_pc[7:2], 2'b00};
            end
            if (req_valid && req_ready) begin
                chk("req_addr", {24'h0, req_addr}, {24'h0, exp_addr});
                gen++;
                exp_q.push_back('{pc: req_addr, data: {8'hC0, gen, 8'h00, req_addr}});
                mem_q.push_back('{due: cyc + lat, data: {8'hC0, gen, 8'h00, req_addr}});
                acc_log.push_back(req_addr);
                exp_addr = exp_addr + 8'd4;
            end
            prev_acc2  = req_valid2;
            prev_addr2 = req_addr2;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic cycle();
        cyc_begin();
        cyc_end();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    task automatic run_until_pops(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (pop_log.size() < n && k < budget) begin
            cycle();
            k++;
        end
        if (pop_log.size() < n) chk({name, "_timeout"}, pop_log.size(), n);
    endtask

    initial begin
        reset = 1'b1; req_ready = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 8'h00;
        rsp_valid = 1'b0; rsp_data = '0; rsp_valid2 = 1'b0; rsp_data2 = '0;

        vecs[0] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 8'h04, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 8'h08, 1'b1, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 8'h0C, 1'b1, 8'h04};
        vecs[4] = '{1'b0, 1'b0, 8'h10, 1'b1, 8'h08};
        vecs[5] = '{1'b0, 1'b0, 8'h10, 1'b1, 8'h08};
        vecs[6] = '{1'b1, 1'b1, 8'h10, 1'b1, 8'h08};
        vecs[7] = '{1'b1, 1'b1, 8'h14, 1'b1, 8'h0C};
        vecs[8] = '{1'b1, 1'b1, 8'h18, 1'b1, 8'h10};
        wrap_addr[0] = 8'hF8; wrap_addr[1] = 8'hFC; wrap_addr[2] = 8'h00; wrap_addr[3] = 8'h04;

        @(negedge clk);
        lat = 1;
        do_reset(3);
        // After the reset edge, before first fetch activity.
        reset = 1'b1;
        cyc_begin();
        chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
        cyc_end();
        reset = 1'b0;
        cyc_begin();
        chk("rst_addr", {24'h0, req_addr}, 32'h0);
        chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", {24'h0, inst_pc}, 32'h0);
        chk("rst_wrap_addr", {24'h0, req_addr2}, 32'hF8);

        // Vector table: 1-cycle memory, startup then a two-cycle back-pressure.
        for (int i = 0; i < 9; i++) begin
            inst_ready = vecs[i].inst_ready;
            if (i > 0) cyc_begin();
            chk($sformatf("vec%0d_req_valid", i), {31'h0, req_valid}, {31'h0, vecs[i].exp_req_valid});
            chk($sformatf("vec%0d_addr", i), {24'h0, req_addr}, {24'h0, vecs[i].exp_addr});
            chk($sformatf("vec%0d_inst_valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].exp_iv});
            if (vecs[i].exp_iv)
                chk($sformatf("vec%0d_inst_pc", i), {24'h0, inst_pc}, {24'h0, vecs[i].exp_pc});
            if (i < 4) begin
                chk($sformatf("wrap%0d_addr", i), {24'h0, req_addr2}, {24'h0, wrap_addr[i]});
                chk($sformatf("wrap%0d_req_valid", i), {31'h0, req_valid2}, 32'h1);
                if (i >= 2) begin
                    chk($sformatf("wrap%0d_inst_pc", i), {24'h0, inst_pc2}, {24'h0, wrap_addr[i-2]});
                    chk($sformatf("wrap%0d_inst_data", i), inst_data2, {8'hC1, 16'h0, wrap_addr[i-2]});
                end
            end
            cyc_end();
        end
        repeat (10) cycle();

        // Downstream stalled from reset: only FIFO_DEPTH requests may issue.
        do_reset(2);
        inst_ready = 1'b0;
        repeat (10) cycle();
        chk("stall_req_count", acc_log.size(), 2);
        cyc_begin();
        chk("stall_req_valid_low", {31'h0, req_valid}, 32'h0);
        cyc_end();
        inst_ready = 1'b1;
        run_until_pops(2, 20, "stall_release");
        repeat (3) cycle();
        if (pop_log.size() >= 2) begin
            chk("stall_pop0", {24'h0, pop_log[0]}, 32'h00);
            chk("stall_pop1", {24'h0, pop_log[1]}, 32'h04);
        end
        if (acc_log.size() >= 3) chk("stall_resume_addr", {24'h0, acc_log[2]}, 32'h08);
        else chk("stall_resume_timeout", acc_log.size(), 3);

        // Redirect with two requests outstanding on a 3-cycle memory.
        lat = 3;
        do_reset(2);
        cycle();
        cycle();
        redirect_valid = 1'b1; redirect_pc = 8'h43;
        cycle();
        redirect_valid = 1'b0;
        pop_log.delete();
        run_until_pops(2, 30, "redirect");
        if (pop_log.size() >= 2) begin
            chk("redirect_pop0", {24'h0, pop_log[0]}, 32'h40);
            chk("redirect_pop1", {24'h0, pop_log[1]}, 32'h44);
        end

        // Redirect coincident with a pop and a response on a 1-cycle memory.
        lat = 1;
        do_reset(2);
        repeat (6) cycle();
        redirect_valid = 1'b1; redirect_pc = 8'h82;
        pop_log.delete();
        cyc_begin();
        chk("coinc_inst_valid", {31'h0, inst_valid}, 32'h1);
        chk("coinc_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        cyc_end();
        redirect_valid = 1'b0;
        chk("coinc_pop_counted", pop_log.size(), 1);
        cyc_begin();
        chk("coinc_flushed", {31'h0, inst_valid}, 32'h0);
        cyc_end();
        pop_log.delete();
        run_until_pops(1, 20, "coinc");
        if (pop_log.size() >= 1) chk("coinc_target_pc", {24'h0, pop_log[0]}, 32'h80);

        // Random traffic on a 2-cycle memory, then reset mid-stream.
        lat = 2;
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            req_ready  = 1'($urandom_range(0, 1));
            inst_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        reset = 1'b1;
        cycle();
        cyc_begin();
        chk("midrst_req_valid", {31'h0, req_valid}, 32'h0);
        chk("midrst_addr", {24'h0, req_addr}, 32'h0);
        chk("midrst_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("midrst_inst_data", inst_data, 32'h0);
        chk("midrst_inst_pc", {24'h0, inst_pc}, 32'h0);
        cyc_end();
        reset = 1'b0; req_ready = 1'b1; inst_ready = 1'b1;
        run_until_pops(3, 20, "midrst");
        if (acc_log.size() >= 1) chk("midrst_first_addr", {24'h0, acc_log[0]}, 32'h00);
        if (pop_log.size() >= 1) chk("midrst_first_pop", {24'h0, pop_log[0]}, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
